// File: rtl/t03_vga_pkg.sv
// Shared VGA timing definitions: default 800x600@60 geometry, total-length helpers and the
// pixel counter type also used by the colour-selection logic.
package t03_vga_pkg;

  typedef logic [10:0] pix_cnt_t;

  localparam int unsigned DefHActive  = 800;
  localparam int unsigned DefHFp      = 40;
  localparam int unsigned DefHSync    = 128;
  localparam int unsigned DefHBp      = 88;
  localparam int unsigned DefVActive  = 600;
  localparam int unsigned DefVFp      = 1;
  localparam int unsigned DefVSync    = 4;
  localparam int unsigned DefVBp      = 23;
  localparam bit          DefHSyncPol = 1'b1;
  localparam bit          DefVSyncPol = 1'b1;
  localparam int unsigned DefClkDiv   = 1;

  // Largest total that still fits a pix_cnt_t.
  localparam int unsigned MaxTotal = 2047;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/t03_vga_pixel_tick.sv
// Pixel clock-enable: one tick every CLK_DIV enabled system clocks; the phase freezes while en=0.
module t03_vga_pixel_tick
  import t03_vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;

  assign tick = en && (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

endmodule

// File: rtl/t03_vga_timing.sv
// VGA raster timing: free-running pixel counters, one-pixel-late registered sync/blank/colour
// outputs, and registered line/frame strobes.
module t03_vga_timing
  import t03_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DefHActive,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_ACTIVE  = DefVActive,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp,
  parameter bit          HSYNC_POL = DefHSyncPol,
  parameter bit          VSYNC_POL = DefVSyncPol,
  parameter int unsigned CLK_DIV   = DefClkDiv
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] color_in,
  output pix_cnt_t   Hcnt,
  output pix_cnt_t   Vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [7:0] color_out,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HTotalInt = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotalInt = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (HTotalInt > MaxTotal || VTotalInt > MaxTotal || CLK_DIV < 1) begin : g_bad_cfg
    $error("t03_vga_timing: totals must fit 11 bits and CLK_DIV must be >= 1");
  end

  localparam pix_cnt_t HActive    = pix_cnt_t'(H_ACTIVE);
  localparam pix_cnt_t HSyncStart = pix_cnt_t'(H_ACTIVE + H_FP);
  localparam pix_cnt_t HSyncEnd   = pix_cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam pix_cnt_t HLast      = pix_cnt_t'(HTotalInt - 1);
  localparam pix_cnt_t VActive    = pix_cnt_t'(V_ACTIVE);
  localparam pix_cnt_t VSyncStart = pix_cnt_t'(V_ACTIVE + V_FP);
  localparam pix_cnt_t VSyncEnd   = pix_cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam pix_cnt_t VLast      = pix_cnt_t'(VTotalInt - 1);

  logic       tick;
  pix_cnt_t   hcnt_q, vcnt_q;
  logic       hsync_q, vsync_q, video_on_q;
  logic [7:0] color_q;
  logic       line_q, frame_q;
  logic       active, hs_raw, vs_raw, h_last, v_last;

  t03_vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  always_comb begin
    active = (hcnt_q < HActive) && (vcnt_q < VActive);
    hs_raw = (hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd);
    vs_raw = (vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd);
    h_last = (hcnt_q == HLast);
    v_last = (vcnt_q == VLast);
  end

  // Stage-2 registers capture the decode of the pixel being left, so they trail the counters
  // by exactly one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      video_on_q <= 1'b0;
      color_q    <= '0;
      hsync_q    <= ~HSYNC_POL;
      vsync_q    <= ~VSYNC_POL;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      line_q  <= tick && h_last;
      frame_q <= tick && h_last && v_last;
      if (tick) begin
        hcnt_q <= h_last ? '0 : hcnt_q + 1'b1;
        if (h_last) begin
          vcnt_q <= v_last ? '0 : vcnt_q + 1'b1;
        end
        video_on_q <= active;
        color_q    <= active ? color_in : 8'h00;
        hsync_q    <= ~(hs_raw ^ HSYNC_POL);
        vsync_q    <= ~(vs_raw ^ VSYNC_POL);
      end
    end
  end

  assign Hcnt        = hcnt_q;
  assign Vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign color_out   = color_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_t03_vga_timing.sv
// Scoreboard bench: a tick-count raster model predicts every output after each clock for a
// full-size CLK_DIV=1 instance and a small CLK_DIV=4 instance with mixed sync polarity.
module tb_t03_vga_timing;
  import t03_vga_pkg::*;

  typedef struct {
    longint ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div;
    bit     hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        vid;
    logic [7:0]  col;
    logic        ls;
    logic        fs;
  } obs_t;

  localparam int NumCycles = 7000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [7:0] cin_a, cin_b;
  pix_cnt_t   hcnt_a, vcnt_a, hcnt_b, vcnt_b;
  logic       hs_a, vs_a, vid_a, ls_a, fs_a, hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [7:0] cout_a, cout_b;

  t03_vga_timing u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .color_in(cin_a),
    .Hcnt(hcnt_a), .Vcnt(vcnt_a), .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
    .color_out(cout_a), .line_start(ls_a), .frame_start(fs_a)
  );

  t03_vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CLK_DIV(4)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .color_in(cin_b),
    .Hcnt(hcnt_b), .Vcnt(vcnt_b), .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
    .color_out(cout_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  obs_t exp_q_a[$];
  obs_t exp_q_b[$];
  obs_t act_a, act_b;

  always_comb act_a = {hcnt_a, vcnt_a, hs_a, vs_a, vid_a, cout_a, ls_a, fs_a};
  always_comb act_b = {hcnt_b, vcnt_b, hs_b, vs_b, vid_b, cout_b, ls_b, fs_b};

  // Outputs after an edge depend only on: ticks since reset (k), enabled clocks (nen), and the
  // pixel that the most recent tick left.
  function automatic void model_step(input cfg_t c, input logic r, input logic e,
                                     input logic [7:0] ci, inout longint k, inout longint nen,
                                     inout obs_t o);
    longint ht, vt, h, v;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    if (r) begin
      k = 0; nen = 0;
      o.vid = 1'b0; o.col = 8'h00; o.hs = ~c.hpol; o.vs = ~c.vpol; o.ls = 1'b0; o.fs = 1'b0;
    end else begin
      o.ls = 1'b0; o.fs = 1'b0;
      if (e) begin
        nen++;
        if (nen % c.div == 0) begin
          h = k % ht;
          v = (k / ht) % vt;
          o.vid = (h < c.ha) && (v < c.va);
          o.col = o.vid ? ci : 8'h00;
          o.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
          o.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
          o.ls  = (h == ht - 1);
          o.fs  = o.ls && (v == vt - 1);
          k++;
        end
      end
    end
    o.h = 11'(k % ht);
    o.v = 11'((k / ht) % vt);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b vid=%b col=%h ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b vid=%b col=%h ls=%b fs=%b",
               name, $time, got.h, got.v, got.hs, got.vs, got.vid, got.col, got.ls, got.fs,
               want.h, want.v, want.hs, want.vs, want.vid, want.col, want.ls, want.fs);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q_a.size() > 0) check("dut_a", act_a, exp_q_a.pop_front());
    if (exp_q_b.size() > 0) check("dut_b", act_b, exp_q_b.pop_front());
  end

  cfg_t   cfg_a, cfg_b;
  longint ka, nen_a, kb, nen_b;
  obs_t   ma, mb;
  int     a_rst_left;
  bit     a_reset_done;
  longint mode;

  initial begin
    cfg_a = '{ha: 800, hfp: 40, hsw: 128, hbp: 88, va: 600, vfp: 1, vsw: 4, vbp: 23, div: 1,
              hpol: 1'b1, vpol: 1'b1};
    cfg_b = '{ha: 16, hfp: 2, hsw: 3, hbp: 2, va: 6, vfp: 1, vsw: 2, vbp: 3, div: 4,
              hpol: 1'b0, vpol: 1'b1};
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0; cin_a = '0; cin_b = '0;
    ka = 0; nen_a = 0; kb = 0; nen_b = 0; ma = '0; mb = '0;
    a_rst_left = 0; a_reset_done = 1'b0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk);
      #1;
      // Instance A: mid-frame reset at line 2, pixel 500, held for two clocks.
      if (!a_reset_done && cyc > 2 && ka == 2 * 1056 + 500) begin
        a_rst_left = 2;
        a_reset_done = 1'b1;
      end
      rst_a = (cyc < 2) || (a_rst_left > 0);
      if (a_rst_left > 0) a_rst_left--;
      en_a = rst_a ? 1'($urandom) : ($urandom_range(0, 49) != 0);
      mode = (ka / 1056) % 3;
      if (mode == 0)      cin_a = 8'($urandom);
      else if (mode == 1) cin_a = 8'hFF;
      else                cin_a = 8'(ka % 1056);
      model_step(cfg_a, rst_a, en_a, cin_a, ka, nen_a, ma);
      exp_q_a.push_back(ma);

      // Instance B: random enable gaps, a fixed 10-clock freeze and a mid-frame reset.
      rst_b = (cyc < 2) || (cyc == 3000) || (cyc == 3001);
      if (cyc >= 700 && cyc < 710) en_b = 1'b0;
      else if (rst_b)              en_b = 1'($urandom);
      else                         en_b = ($urandom_range(0, 9) != 0);
      cin_b = 8'($urandom);
      model_step(cfg_b, rst_b, en_b, cin_b, kb, nen_b, mb);
      exp_q_b.push_back(mb);
    end

    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q_a.size() + exp_q_b.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0",
               exp_q_a.size() + exp_q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
